// File: rtl/gsram_ctrl_pkg.sv
// Shared types and constants for the word-to-bit SRAM controller.
package gsram_ctrl_pkg;

  localparam int RD_LAT_MAX = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RDWAIT,
    RSP,
    CLEAR
  } state_t;

  // Word-address width: bit-address bits minus the in-word bit index.
  function automatic int word_abits(input int abits, input int wbits);
    return abits - $clog2(wbits);
  endfunction

endpackage

// File: rtl/gsram_word_ctrl_if.sv
// Word-level request/response channel between the datapath and gsram_word_ctrl.
interface gsram_word_ctrl_if
  import gsram_ctrl_pkg::*;
#(
  parameter int AW    = word_abits(14, 8),
  parameter int WBITS = 8
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AW-1:0]    req_addr;
  logic [WBITS-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WBITS-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/gsram_rd_capture.sv
// Read-return pipeline: tags each issued read with its bit index and drops Q
// into the assembled word when the tag emerges RD_LAT cycles later.
module gsram_rd_capture #(
  parameter int WBITS  = 8,
  parameter int RD_LAT = 1,
  localparam int IW    = $clog2(WBITS)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             issue,
  input  logic [IW-1:0]    issue_idx,
  input  logic             q,
  output logic [WBITS-1:0] rdata,
  output logic             last
);
  logic [RD_LAT-1:0] vld_reg;
  logic [RD_LAT-1:0] vld_in;
  logic [IW-1:0]     tag_reg [RD_LAT];
  logic [IW-1:0]     tag_in  [RD_LAT];

  assign vld_in[0] = issue;
  assign tag_in[0] = issue_idx;

  genvar gi;
  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_stage
      assign vld_in[gi] = vld_reg[gi-1];
      assign tag_in[gi] = tag_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      vld_reg <= '0;
      rdata   <= '0;
      for (int k = 0; k < RD_LAT; k++) tag_reg[k] <= '0;
    end else begin
      vld_reg <= vld_in;
      tag_reg <= tag_in;
      if (vld_reg[RD_LAT-1]) rdata[tag_reg[RD_LAT-1]] <= q;
    end
  end

  assign last = vld_reg[RD_LAT-1] && (tag_reg[RD_LAT-1] == IW'(WBITS-1));
endmodule

// File: rtl/gsram_word_ctrl.sv
// Serialises word reads/writes onto one port of a 1-bit-wide SRAM, LSB first.
// Define GSRAM_WORD_CTRL_CLEAR_EN to zero the whole array after every reset.
module gsram_word_ctrl
  import gsram_ctrl_pkg::*;
#(
  parameter int ABITS  = 14,
  parameter int WBITS  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  gsram_word_ctrl_if.slave bus,
  output logic [ABITS-1:0] A,
  output logic             D,
  input  logic             Q,
  output logic             WE,
  output logic             WEM,
  output logic             CE
);
  localparam int AW = word_abits(ABITS, WBITS);
  localparam int IW = $clog2(WBITS);

  generate
    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("gsram_word_ctrl: RD_LAT out of range");
    end
  endgenerate

  state_t           state_reg;
  logic [AW-1:0]    word_reg;
  logic [WBITS-1:0] wdata_reg;
  logic [IW-1:0]    idx_reg;
  logic [IW-1:0]    idx_next;
  logic [ABITS-1:0] a_reg;
  logic             d_reg, we_reg, wem_reg, ce_reg;
  logic             req_ready_reg, rsp_valid_reg;
  logic             cap_last;
  logic [WBITS-1:0] cap_rdata;

  assign idx_next = idx_reg + 1'b1;

  gsram_rd_capture #(.WBITS(WBITS), .RD_LAT(RD_LAT)) u_cap (
    .clk       (CLK),
    .srst      (RST),
    .issue     (ce_reg & ~we_reg),
    .issue_idx (idx_reg),
    .q         (Q),
    .rdata     (cap_rdata),
    .last      (cap_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
`ifdef GSRAM_WORD_CTRL_CLEAR_EN
      state_reg     <= CLEAR;
      req_ready_reg <= 1'b0;
`else
      state_reg     <= IDLE;
      req_ready_reg <= 1'b1;
`endif
      rsp_valid_reg <= 1'b0;
      word_reg      <= '0;
      wdata_reg     <= '0;
      idx_reg       <= '0;
      a_reg         <= '0;
      d_reg         <= 1'b0;
      we_reg        <= 1'b0;
      wem_reg       <= 1'b0;
      ce_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Bit 0 goes out on the handshake edge so it reaches the SRAM at t+1.
          if (bus.req_valid) begin
            req_ready_reg <= 1'b0;
            word_reg      <= bus.req_addr;
            wdata_reg     <= bus.req_wdata;
            idx_reg       <= '0;
            a_reg         <= {bus.req_addr, {IW{1'b0}}};
            ce_reg        <= 1'b1;
            we_reg        <= bus.req_write;
            wem_reg       <= bus.req_write;
            if (bus.req_write) begin
              d_reg     <= bus.req_wdata[0];
              state_reg <= WR;
            end else begin
              state_reg <= RD;
            end
          end
        end
        WR: begin
          if (idx_reg == IW'(WBITS-1)) begin
            ce_reg        <= 1'b0;
            we_reg        <= 1'b0;
            wem_reg       <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            idx_reg <= idx_next;
            a_reg   <= {word_reg, idx_next};
            d_reg   <= wdata_reg[idx_next];
          end
        end
        RD: begin
          if (idx_reg == IW'(WBITS-1)) begin
            ce_reg    <= 1'b0;
            state_reg <= RDWAIT;
          end else begin
            idx_reg <= idx_next;
            a_reg   <= {word_reg, idx_next};
          end
        end
        RDWAIT: begin
          if (cap_last) begin
            rsp_valid_reg <= 1'b1;
            state_reg     <= RSP;
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        CLEAR: begin
`ifdef GSRAM_WORD_CTRL_CLEAR_EN
          // First CLEAR cycle only arms the port; then one bit per cycle.
          if (!ce_reg) begin
            ce_reg  <= 1'b1;
            we_reg  <= 1'b1;
            wem_reg <= 1'b1;
            d_reg   <= 1'b0;
            a_reg   <= '0;
          end else if (&a_reg) begin
            ce_reg        <= 1'b0;
            we_reg        <= 1'b0;
            wem_reg       <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            a_reg <= a_reg + 1'b1;
          end
`else
          state_reg <= IDLE;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = cap_rdata;
  assign A   = a_reg;
  assign D   = d_reg;
  assign WE  = we_reg;
  assign WEM = wem_reg;
  assign CE  = ce_reg;
endmodule

// File: tb/tb_gsram_word_ctrl.sv
// Bench for gsram_word_ctrl: two instances (RD_LAT=1 and 3), each with a bit SRAM model,
// checked against a word-level reference memory.
module tb_gsram_word_ctrl;
  import gsram_ctrl_pkg::*;

  localparam int ABITS = 14;
  localparam int WBITS = 8;
  localparam int AW    = word_abits(ABITS, WBITS);
  localparam int NDUT  = 2;
  localparam int BOUND = 20000;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NDUT-1:0]            req_valid_v = '0, req_write_v = '0, rsp_ready_v = '0;
  logic [NDUT-1:0][AW-1:0]    req_addr_v  = '0;
  logic [NDUT-1:0][WBITS-1:0] req_wdata_v = '0;
  logic [NDUT-1:0]            req_ready_v, rsp_valid_v, d_v, we_v, wem_v, ce_v, q_v;
  logic [NDUT-1:0][WBITS-1:0] rsp_rdata_v;
  logic [NDUT-1:0][ABITS-1:0] a_v;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      gsram_word_ctrl_if #(.AW(AW), .WBITS(WBITS)) bus ();
      assign bus.req_valid   = req_valid_v[gi];
      assign bus.req_write   = req_write_v[gi];
      assign bus.req_addr    = req_addr_v[gi];
      assign bus.req_wdata   = req_wdata_v[gi];
      assign bus.rsp_ready   = rsp_ready_v[gi];
      assign req_ready_v[gi] = bus.req_ready;
      assign rsp_valid_v[gi] = bus.rsp_valid;
      assign rsp_rdata_v[gi] = bus.rsp_rdata;

      gsram_word_ctrl #(.ABITS(ABITS), .WBITS(WBITS), .RD_LAT(lat_of(gi))) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus),
        .A   (a_v[gi]),
        .D   (d_v[gi]),
        .Q   (q_v[gi]),
        .WE  (we_v[gi]),
        .WEM (wem_v[gi]),
        .CE  (ce_v[gi])
      );

      // Behavioural bit SRAM: Q valid RD_LAT cycles after the address cycle.
      logic sram [2**ABITS] = '{default: 1'b0};
      logic [2:0] qpipe = '0;
      always @(posedge clk) begin
        if (ce_v[gi] && we_v[gi] && wem_v[gi]) sram[a_v[gi]] <= d_v[gi];
        if (ce_v[gi] && !we_v[gi]) qpipe[0] <= sram[a_v[gi]];
        qpipe[2:1] <= qpipe[1:0];
      end
      assign q_v[gi] = qpipe[lat_of(gi)-1];
    end
  endgenerate

  logic [WBITS-1:0] ref_mem [NDUT][2**AW];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic after_reset();
`ifdef GSRAM_WORD_CTRL_CLEAR_EN
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < 2**AW; w++) ref_mem[d][w] = '0;
`endif
  endtask

  task automatic issue(input int d, input bit wr, input logic [AW-1:0] addr,
                       input logic [WBITS-1:0] data);
    int n = 0;
    @(negedge clk);
    req_valid_v[d] = 1'b1;
    req_write_v[d] = wr;
    req_addr_v[d]  = addr;
    req_wdata_v[d] = data;
    while (!req_ready_v[d] && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d_accept", d), 32'(n < BOUND), 32'd1);
    @(posedge clk);
    #1 req_valid_v[d] = 1'b0;
  endtask

  task automatic do_write(input int d, input logic [AW-1:0] addr, input logic [WBITS-1:0] data);
    issue(d, 1'b1, addr, data);
    for (int i = 0; i < WBITS; i++) begin
      @(negedge clk);
      chk($sformatf("dut%0d_wr_bit%0d", d, i),
          {ce_v[d], we_v[d], wem_v[d], d_v[d], req_ready_v[d], a_v[d]},
          {1'b1, 1'b1, 1'b1, data[i], 1'b0, ABITS'(int'(addr) * WBITS + i)});
    end
    @(negedge clk);
    chk($sformatf("dut%0d_wr_done", d), {req_ready_v[d], ce_v[d], we_v[d]}, 3'b100);
    ref_mem[d][addr] = data;
    $display("txn dut%0d WRITE addr=0x%03h data=0x%02h", d, addr, data);
  endtask

  task automatic do_read(input int d, input logic [AW-1:0] addr, input int hold,
                         output logic [WBITS-1:0] got);
    int c;
    logic [WBITS-1:0] exp;
    exp = ref_mem[d][addr];
    issue(d, 1'b0, addr, '0);
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c <= WBITS)
        chk($sformatf("dut%0d_rd_addr%0d", d, c - 1),
            {ce_v[d], we_v[d], wem_v[d], a_v[d]},
            {1'b1, 1'b0, 1'b0, ABITS'(int'(addr) * WBITS + c - 1)});
      if (rsp_valid_v[d]) break;
    end
    chk($sformatf("dut%0d_rsp_latency", d), c, WBITS + lat_of(d) + 1);
    got = rsp_rdata_v[d];
    chk($sformatf("dut%0d_rdata", d), got, exp);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk($sformatf("dut%0d_rsp_hold%0d", d, k),
          {rsp_valid_v[d], req_ready_v[d], rsp_rdata_v[d]}, {1'b1, 1'b0, got});
    end
    rsp_ready_v[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready_v[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("dut%0d_rsp_done", d), {rsp_valid_v[d], req_ready_v[d]}, 2'b01);
    $display("txn dut%0d READ  addr=0x%03h data=0x%02h hold=%0d lat=%0d", d, addr, got, hold, c);
  endtask

  typedef struct {
    bit               wr;
    logic [AW-1:0]    addr;
    logic [WBITS-1:0] wdata;
    int               hold;
    logic [WBITS-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [WBITS-1:0] got;
    int n;
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < 2**AW; w++) ref_mem[d][w] = '0;

    vecs[0] = '{1'b1, 11'h005, 8'hA5, 0, 8'h00};
    vecs[1] = '{1'b0, 11'h005, 8'h00, 0, 8'hA5};
    vecs[2] = '{1'b1, 11'h7FF, 8'hFF, 0, 8'h00};
    vecs[3] = '{1'b1, 11'h000, 8'h01, 0, 8'h00};
    vecs[4] = '{1'b0, 11'h7FF, 8'h00, 0, 8'hFF};
    vecs[5] = '{1'b0, 11'h000, 8'h00, 0, 8'h01};
    vecs[6] = '{1'b0, 11'h005, 8'h00, 5, 8'hA5};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("dut%0d_rst_outputs", d),
          {rsp_valid_v[d], ce_v[d], we_v[d], wem_v[d], d_v[d], a_v[d], rsp_rdata_v[d]}, '0);
`ifdef GSRAM_WORD_CTRL_CLEAR_EN
      chk($sformatf("dut%0d_rst_ready", d), req_ready_v[d], 1'b0);
`else
      chk($sformatf("dut%0d_rst_ready", d), req_ready_v[d], 1'b1);
`endif
    end
    rst = 1'b0;
    after_reset();

    // Directed vectors on the RD_LAT=1 instance
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].wr) do_write(0, vecs[i].addr, vecs[i].wdata);
      else begin
        do_read(0, vecs[i].addr, vecs[i].hold, got);
        chk($sformatf("vec%0d_rdata", i), got, vecs[i].exp);
      end
    end

    // RD_LAT=3 instance: neighbouring words expose any bit shift
    do_write(1, 11'h3C5, 8'h96);
    do_write(1, 11'h3C6, 8'h5A);
    do_read(1, 11'h3C5, 0, got);
    chk("lat3_word_3c5", got, 8'h96);
    do_read(1, 11'h3C6, 2, got);
    chk("lat3_word_3c6", got, 8'h5A);

    // Reset at write bit 3: bits 0..3 land, the rest do not
    do_write(0, 11'h010, 8'h00);
    issue(0, 1'b1, 11'h010, 8'hFF);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wr_port", {ce_v[0], we_v[0], wem_v[0], d_v[0], a_v[0]}, '0);
    chk("rst_mid_wr_rsp", rsp_valid_v[0], 1'b0);
    rst = 1'b0;
    ref_mem[0][11'h010] = 8'h0F;
    after_reset();
    do_read(0, 11'h010, 0, got);

    // Reset while a response is pending discards it
    do_write(0, 11'h020, 8'h3C);
    issue(0, 1'b0, 11'h020, '0);
    n = 0;
    while (!rsp_valid_v[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_before_rst", rsp_valid_v[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rsp", {rsp_valid_v[0], rsp_rdata_v[0]}, '0);
    rst = 1'b0;
    after_reset();

    // Random traffic on a small address window so reads hit earlier writes
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] addr;
      addr = AW'(11'h100 + $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        do_write(0, addr, WBITS'($urandom));
      else
        do_read(0, addr, $urandom_range(0, 3), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
